// File: rtl/mul_result_serializer_pkg.sv
// mul_pkg: shared widths, FSM state type and payload layout for the multiplier result path
package mul_pkg;
  localparam int P_WIDTH = 6;
  localparam int FRAME_BITS = P_WIDTH + 4;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  typedef struct packed {
    logic sign;
    logic [P_WIDTH-1:0] p;
  } payload_t;
endpackage

// File: rtl/mul_result_serializer_if.sv
// mul_result_serializer_if: valid/ready product handshake
// master drives in_valid/in_p/in_sign and samples in_ready; slave is the reverse
interface mul_result_serializer_if #(parameter int P_WIDTH = mul_pkg::P_WIDTH);
  logic in_valid, in_ready, in_sign;
  logic [P_WIDTH-1:0] in_p;
  modport master(output in_valid, in_p, in_sign, input in_ready);
  modport slave(input in_valid, in_p, in_sign, output in_ready);
endinterface

// File: rtl/mul_result_fifo.sv
// mul_result_fifo: synchronous FIFO of WIDTH-bit entries, DEPTH a power of two
// ports: clk, rst (async active-high), push/din, pop/dout (show-ahead), full, empty
module mul_result_fifo #(
  parameter int WIDTH = 7,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int NW = $clog2(DEPTH + 1);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [NW-1:0] count;
  logic wr, rd;
  assign full = count == NW'(DEPTH);
  assign empty = count == '0;
  // full refuses a push even when a pop frees a slot in the same cycle
  assign wr = push && !full;
  assign rd = pop && !empty;
  assign dout = mem[rp];
  always_ff @(posedge clk) if (wr) mem[wp] <= din;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      wp <= wp + AW'(wr);
      rp <= rp + AW'(rd);
      count <= count + NW'(wr) - NW'(rd);
    end
  end
endmodule

// File: rtl/mul_result_serializer.sv
// mul_result_serializer: buffers {sign, p} products and sends each as a framed, even-parity serial word
// ports: clk, reset (async active-high), bus (slave handshake), ser_out (idles high),
//        ser_busy (frame in flight), frame_done (one-cycle pulse after each frame)
module mul_result_serializer #(
  parameter int P_WIDTH = mul_pkg::P_WIDTH,
  parameter int DEPTH = 2,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic reset,
  mul_result_serializer_if.slave bus,
  output logic ser_out,
  output logic ser_busy,
  output logic frame_done
);
  import mul_pkg::*;
  localparam int CW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW = $clog2(P_WIDTH + 1);
  logic [1:0] rs;
  logic rst, full, empty, pop, bit_end, par, par_n, ser_n, done_n;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [IW-1:0] idx, idx_n;
  logic [P_WIDTH:0] sh, sh_n, dout;
  // reset asserts immediately but releases two edges later, clean of the clock
  always_ff @(posedge clk or posedge reset) rs <= reset ? 2'b11 : {rs[0], 1'b0};
  assign rst = rs[1];
  mul_result_fifo #(.WIDTH(P_WIDTH + 1), .DEPTH(DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .push(bus.in_valid), .pop(pop),
    .din({bus.in_sign, bus.in_p}), .dout(dout), .full(full), .empty(empty)
  );
  assign bus.in_ready = !full;
  assign ser_busy = state != IDLE;
  assign bit_end = cnt == CW'(CLKS_PER_BIT - 1);
  always_comb begin
    state_n = state;
    cnt_n = (state == IDLE || bit_end) ? '0 : cnt + CW'(1);
    idx_n = idx;
    sh_n = sh;
    par_n = par;
    ser_n = ser_out;
    done_n = 1'b0;
    pop = 1'b0;
    case (state)
      IDLE: pop = !empty;
      START: if (bit_end) begin
        state_n = DATA;
        ser_n = sh[0];
      end
      DATA: if (bit_end) begin
        if (idx == IW'(P_WIDTH)) begin
          state_n = PARITY;
          idx_n = '0;
          ser_n = par;
        end else begin
          idx_n = idx + IW'(1);
          sh_n = sh >> 1;
          ser_n = sh[1];
        end
      end
      PARITY: if (bit_end) begin
        state_n = STOP;
        ser_n = 1'b1;
      end
      STOP: if (bit_end) begin
        state_n = IDLE;
        done_n = 1'b1;
        pop = !empty;
      end
      default: state_n = IDLE;
    endcase
    // a pop from IDLE or from the end of STOP starts the next frame with no gap
    if (pop) begin
      state_n = START;
      sh_n = dout;
      par_n = ^dout;
      ser_n = 1'b0;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      sh <= '0;
      par <= 1'b0;
      ser_out <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      idx <= idx_n;
      sh <= sh_n;
      par <= par_n;
      ser_out <= ser_n;
      frame_done <= done_n;
    end
  end
endmodule

// File: tb/tb_mul_result_serializer.sv
// tb_mul_result_serializer: directed checks of framing, back-to-back flow, full flag, reset abort and CLKS_PER_BIT=1
module tb_mul_result_serializer;
  import mul_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic ser_out, ser_busy, frame_done, ser1, busy1, done1;
  int n_cmp = 0;
  int n_err = 0;
  localparam payload_t PA = 7'b1_001101;
  localparam payload_t PZ = 7'b0_000000;
  localparam payload_t PO = 7'b0_111111;
  localparam payload_t PB = 7'b1_000001;
  localparam logic [9:0] F_A = 10'b1010011010;
  localparam logic [9:0] F_Z = 10'b1000000000;
  localparam logic [9:0] F_O = 10'b1001111110;
  localparam logic [9:0] F_B = 10'b1010000010;
  localparam int FC = FRAME_BITS * 4;
  logic [9:0] fb;
  mul_result_serializer_if b ();
  mul_result_serializer_if b1 ();
  mul_result_serializer dut (
    .clk(clk), .reset(reset), .bus(b),
    .ser_out(ser_out), .ser_busy(ser_busy), .frame_done(frame_done)
  );
  mul_result_serializer #(.CLKS_PER_BIT(1)) dut1 (
    .clk(clk), .reset(reset), .bus(b1),
    .ser_out(ser1), .ser_busy(busy1), .frame_done(done1)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_cmp++;
    assert (o === e) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask
  task automatic xfer(input string tag, input int n, input payload_t v0, v1, v2, v3, input logic [39:0] st);
    payload_t v[4];
    int k;
    logic rdy;
    v[0] = v0; v[1] = v1; v[2] = v2; v[3] = v3;
    k = 0;
    b.in_valid = 1'b1;
    {b.in_sign, b.in_p} = v[0];
    for (int c = 0; c < FC * n + 3; c++) begin
      rdy = b.in_ready;
      if (c >= 2 && c < FC * n + 2) begin
        chk({tag, "_ser"}, ser_out, st[(c - 2) / 4]);
        chk({tag, "_busy"}, ser_busy, 1);
      end
      if (c == 2) begin
        chk({tag, "_rdy2"}, b.in_ready, 1);
        chk({tag, "_cnt2"}, dut.u_fifo.count, n >= 2);
      end
      if (c == 3) chk({tag, "_rdy3"}, b.in_ready, n < 3);
      if (c == FC * n + 2) chk({tag, "_idle"}, ser_busy, 0);
      chk({tag, "_done"}, frame_done, c > 2 && (c - 2) % FC == 0);
      @(negedge clk);
      if (rdy && b.in_valid) begin
        k++;
        if (k == n) b.in_valid = 1'b0;
        else {b.in_sign, b.in_p} = v[k];
      end
    end
    chk({tag, "_accepted"}, k, n);
  endtask
  initial begin
    b.in_valid = 1'b0; b.in_p = '0; b.in_sign = 1'b0;
    b1.in_valid = 1'b0; b1.in_p = '0; b1.in_sign = 1'b0;
    fb = F_B;
    @(negedge clk);
    chk("rst_ser", ser_out, 1);
    chk("rst_busy", ser_busy, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_rdy", b.in_ready, 1);
    chk("rst_ser1", ser1, 1);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    xfer("fa", 1, PA, PZ, PZ, PZ, {30'b0, F_A});
    xfer("fz", 1, PZ, PZ, PZ, PZ, {30'b0, F_Z});
    xfer("fo", 1, PO, PZ, PZ, PZ, {30'b0, F_O});
    b1.in_valid = 1'b1;
    {b1.in_sign, b1.in_p} = PB;
    @(negedge clk);
    b1.in_valid = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      chk("c1_ser", ser1, fb[i]);
      chk("c1_busy", busy1, 1);
      @(negedge clk);
    end
    chk("c1_done", done1, 1);
    chk("c1_idle", busy1, 0);
    xfer("b2b", 4, PA, PZ, PO, PB, {F_B, F_O, F_Z, F_A});
    b.in_valid = 1'b1;
    {b.in_sign, b.in_p} = PA;
    @(negedge clk);
    {b.in_sign, b.in_p} = PZ;
    @(negedge clk);
    b.in_valid = 1'b0;
    repeat (17) @(negedge clk);
    chk("ab_bit3", ser_out, 1);
    chk("ab_queued", dut.u_fifo.count, 1);
    reset = 1'b1;
    #1;
    chk("ab_ser", ser_out, 1);
    chk("ab_busy", ser_busy, 0);
    chk("ab_done", frame_done, 0);
    chk("ab_rdy", b.in_ready, 1);
    chk("ab_cnt", dut.u_fifo.count, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (60) begin
      @(negedge clk);
      chk("ab_quiet_ser", ser_out, 1);
      chk("ab_quiet_busy", ser_busy, 0);
    end
    xfer("post", 1, PO, PZ, PZ, PZ, {30'b0, F_O});
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
